aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
Iterative AES-128 encryption engine controller. It owns one shared round datapath (SubByte, ShiftRows, MixColumns and AddRoundKey instances) and an on-the-fly key schedule, and sequences Nr rounds over one block, one round per clock. It replaces the fully unrolled cipher where area matters. Upstream and downstream connect through valid/ready handshakes.

Parameters:
Nk, 4, key length in 32-bit words; only 4 is legal; elaboration error otherwise.
Nr, 10, number of rounds; must equal Nk+6.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  block and key presented.
in_ready  output  1  sequencer can accept a block.
in_data  input  128  plaintext; bits [127:120] are byte 0.
in_key  input  Nk*32  cipher key; bits [127:120] are byte 0.
out_valid  output  1  ciphertext available.
out_ready  input  1  downstream accepts the ciphertext.
out_data  output  128  ciphertext, same byte order as in_data.
round_idx  output  4  current round number, for debug and observability.

Behaviour:
- One clock; reset is synchronous and active-high, ports named clk and rst.
- States: IDLE, ROUND, DONE. Reset enters IDLE.
- Reset values: in_ready=1, out_valid=0, out_data=0, round_idx=0, internal state and round-key registers = 0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at cycle T: state_reg<=in_data^in_key; rk_reg<=in_key; round_idx<=1; go to ROUND.
- ROUND (round_idx=r, 1..Nr):
  - nk = key_step(rk_reg, Rcon[r]).
  - r<Nr: state_reg<=MixColumns(ShiftRows(SubByte(state_reg)))^nk.
  - r=Nr: MixColumns is bypassed.
  - rk_reg<=nk; round_idx<=r+1.
  - When r=Nr: out_data<=result; go to DONE.
- DONE:
  - out_valid=1, round_idx=0.
  - out_data is stable until the handshake completes.
  - On out_ready: go to IDLE; out_data keeps its last value.
- Latency: accept at cycle T gives out_valid high from T+Nr+1 (T+11). Best-case throughput is one block per Nr+2 cycles.
- in_ready is 0 in ROUND and DONE; there is no overlap of accept with output.
- in_data and in_key are sampled only on the accept edge; later changes are ignored.
- out_ready in IDLE or ROUND is ignored.
- in_valid asserted while busy is not dropped; it is accepted on the first IDLE cycle.
- Reset asserted in any state: the in-flight block is discarded, with no out_valid pulse. All outputs take reset values on the next edge.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- key_step(w0..w3, rc):
  - t = SubWord(RotWord(w3)) ^ {rc,00,00,00}.
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.

Optional Feature:
- Macro AES_SEQ_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in ROUND or DONE: go to IDLE next cycle; out_valid forced 0; round_idx=0; out_data unchanged.
  - abort in IDLE is ignored.
  - abort and in_valid together in IDLE: the block is accepted.
  - rst has priority over abort.
- Undefined: no abort port; a block always completes.

Decomposition:
- Package aes_pkg contains:
  - state encoding constants (IDLE=2'd0, ROUND=2'd1, DONE=2'd2);
  - the Rcon table;
  - the byte S-box function used by SubWord;
  - the AES128_NK and AES128_NR constants.
- One sub-module, aes_key_step: combinational one-round key schedule (128-bit key in, rcon in, 128-bit key out).
- The round datapath reuses the existing SubByte, ShiftRows, MixColumns and AddRoundKey modules.

Test Plan:
- FIPS-197 C.1: in_data=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, accept at T -> out_valid at T+11, out_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 B: 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> 3925841d02dc09fbdc118597196a0b32.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_valid and out_data stable, in_ready=0; release -> in_ready=1 the cycle after the handshake.
- Back-to-back: keep in_valid high with two blocks, and toggle in_data/in_key while busy -> both ciphertexts correct; mid-run toggling has no effect; second accept occurs the cycle after the first output handshake.
- Reset mid-operation: assert rst with round_idx=5 -> next cycle in_ready=1, out_valid=0, round_idx=0; no stale output later; the next block result is correct.
- With AES_SEQ_ABORT_EN defined: abort at round_idx=3 -> IDLE next cycle, no out_valid; the following C.1 vector still yields 69c4e0d86a7b0430d8cdb78070b4c55a.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, state encoding and byte-level round helpers
package aes_pkg;
  localparam int AES128_NK = 4;
  localparam int AES128_NR = 10;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // Multiplicative inverse as b^254 (square-and-multiply), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq, inv;
    sq = b;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction
  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction
endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: combinational single-round AES-128 key expansion
//   key      : current round key (w0 in bits [127:96])
//   rcon     : round constant byte
//   next_key : following round key
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);
  logic [31:0] w3, t, n0, n1, n2, n3;
  assign w3 = key[31:0];
  assign t = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
  assign n0 = key[127:96] ^ t;
  assign n1 = key[95:64] ^ n0;
  assign n2 = key[63:32] ^ n1;
  assign n3 = key[31:0] ^ n2;
  assign next_key = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 encryptor, one round per clock
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : accept in_data (plaintext) and in_key
//   out_valid/out_ready : present out_data (ciphertext) until taken
//   round_idx           : round in progress (0 when not in ROUND)
//   abort               : present only with AES_SEQ_ABORT_EN; drops the block in flight
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int Nk = AES128_NK,
  parameter int Nr = AES128_NR
) (
  input  logic             clk,
  input  logic             rst,
`ifdef AES_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [Nk*32-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [3:0]       round_idx
);
  if (Nk != AES128_NK || Nr != Nk + 6) begin : g_param_err
    $error("aes_round_sequencer supports only Nk=4, Nr=10");
  end
  logic [1:0] st;
  logic [127:0] state_reg, rk_reg, nk, sr, rnd_out;
  logic last, kill;
  aes_key_step u_key_step (.key(rk_reg), .rcon(RCON[round_idx]), .next_key(nk));
  assign sr = shift_rows(sub_bytes(state_reg));
  assign last = round_idx == 4'(Nr);
  assign rnd_out = (last ? sr : mix_columns(sr)) ^ nk;
  assign in_ready = st == IDLE;
  assign out_valid = st == DONE;
`ifdef AES_SEQ_ABORT_EN
  assign kill = abort && st != IDLE;
`else
  assign kill = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      state_reg <= '0;
      rk_reg <= '0;
      round_idx <= '0;
      out_data <= '0;
    end else if (kill) begin
      st <= IDLE;
      round_idx <= '0;
    end else if (st == IDLE) begin
      if (in_valid) begin
        state_reg <= in_data ^ in_key;
        rk_reg <= in_key;
        round_idx <= 4'd1;
        st <= ROUND;
      end
    end else if (st == ROUND) begin
      state_reg <= rnd_out;
      rk_reg <= nk;
      round_idx <= last ? 4'd0 : round_idx + 4'd1;
      if (last) begin
        out_data <= rnd_out;
        st <= DONE;
      end
    end else if (out_ready) begin
      st <= IDLE;
    end
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: randomized self-checking bench with a FIPS-197-style reference model
module tb_aes_round_sequencer;
  localparam int NR = 10;
`ifdef AES_SEQ_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, abort = 1'b0;
  logic [127:0] in_data = '0, in_key = '0;
  logic in_ready, out_valid;
  logic [127:0] out_data;
  logic [3:0] round_idx;
  int n_tests = 0, n_fail = 0, cyc = 0;
  bit chk_en = 1'b0;
  logic [7:0] sb [256];
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_round_sequencer dut (
    .clk(clk), .rst(rst),
`ifdef AES_SEQ_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .round_idx(round_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Textbook cipher: full key expansion up front, then byte-array rounds.
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]] ^ rc, sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= NR; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) s[row+4*c] = t[row+4*((c+row)%4)];
      if (r < NR)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
          s[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
        end
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) s[4*c+j] = s[4*c+j] ^ w[4*r+c][31-8*j -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Transaction-level model: rounds left, done flag, held ciphertext.
  int m_left = 0, m_blocks = 0;
  bit m_done = 1'b0;
  logic [127:0] m_out = '0, m_pend = '0;
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_left = 0; m_done = 0; m_out = '0;
    end else if (ABORT_EN && abort && (m_left > 0 || m_done)) begin
      m_left = 0; m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1; m_out = m_pend; m_blocks++;
      end
    end else if (m_done) begin
      if (out_ready) m_done = 0;
    end else if (in_valid) begin
      m_left = NR; m_pend = aes_enc(in_data, in_key);
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("in_ready", 128'(in_ready), 128'(m_left == 0 && !m_done));
    check("out_valid", 128'(out_valid), 128'(m_done));
    check("round_idx", 128'(round_idx), 128'(m_left > 0 ? NR - m_left + 1 : 0));
    check("out_data", out_data, m_out);
  end

  task automatic accept(input logic [127:0] d, input logic [127:0] k, input bit hold, output int t_acc);
    bit got;
    got = 0; t_acc = -1;
    in_data = d; in_key = k; in_valid = 1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; t_acc = cyc; end
    end
    if (!got) check("accept_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
    if (!hold) in_valid = 0;
  endtask

  task automatic wait_valid(output int t);
    bit got;
    got = 0; t = -1;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; t = cyc; end
    end
    if (!got) check("out_valid_timeout", 128'(0), 128'(1));
  endtask

  task automatic handshake();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ta, tv, tb;
    logic [127:0] d1, k1, d2, k2;
    logic [7:0] inv, sv, cst;
    bit got;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        sv[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sb[x] = sv;
    end
    check("model_fips_c1", aes_enc(C1_PT, C1_K), C1_CT);
    check("model_fips_b", aes_enc(B_PT, B_K), B_CT);
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_round_idx", 128'(round_idx), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    @(posedge clk); #1;
    rst = 0;
    // FIPS-197 C.1 with latency, input changes after accept, and backpressure
    accept(C1_PT, C1_K, 0, ta);
    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_key = {$urandom, $urandom, $urandom, $urandom};
    wait_valid(tv);
    check("latency", 128'(tv - ta), 128'(11));
    check("c1_out", out_data, C1_CT);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_out_data", out_data, C1_CT);
      check("bp_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1;
    handshake();
    @(negedge clk);
    check("post_hs_in_ready", 128'(in_ready), 128'(1));
    check("post_hs_out_valid", 128'(out_valid), 128'(0));
    check("post_hs_out_data", out_data, C1_CT);
    @(posedge clk); #1;
    // FIPS-197 appendix B
    accept(B_PT, B_K, 0, ta);
    wait_valid(tv);
    check("b_out", out_data, B_CT);
    @(posedge clk); #1;
    handshake();
    // Back-to-back with in_valid held and inputs toggling while busy
    d1 = {$urandom, $urandom, $urandom, $urandom}; k1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom}; k2 = {$urandom, $urandom, $urandom, $urandom};
    accept(d1, k1, 1, ta);
    for (int n = 0; n < 8; n++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_key = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    wait_valid(tv);
    check("b2b_first", out_data, aes_enc(d1, k1));
    in_data = d2; in_key = k2;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    @(negedge clk);
    check("b2b_ready_after_hs", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check("b2b_second_accepted", 128'(round_idx), 128'(1));
    wait_valid(tv);
    check("b2b_second", out_data, aes_enc(d2, k2));
    @(posedge clk); #1;
    handshake();
    // Reset in the middle of a block
    accept({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, ta);
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (round_idx == 4'd5) got = 1;
    end
    check("reach_round5", 128'(got), 128'(1));
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_round_idx", 128'(round_idx), 128'(0));
    got = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (out_valid) got = 1;
    end
    check("midrst_no_stale", 128'(got), 128'(0));
    @(posedge clk); #1;
    accept(C1_PT, C1_K, 0, ta);
    wait_valid(tv);
    check("after_rst_c1", out_data, C1_CT);
    @(posedge clk); #1;
    handshake();
`ifdef AES_SEQ_ABORT_EN
    accept(B_PT, B_K, 0, ta);
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (round_idx == 4'd3) got = 1;
    end
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    @(negedge clk);
    check("abort_in_ready", 128'(in_ready), 128'(1));
    check("abort_round_idx", 128'(round_idx), 128'(0));
    got = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (out_valid) got = 1;
    end
    check("abort_no_out", 128'(got), 128'(0));
    @(posedge clk); #1;
    accept(C1_PT, C1_K, 0, ta);
    wait_valid(tv);
    check("after_abort_c1", out_data, C1_CT);
    @(posedge clk); #1;
    handshake();
`endif
    // Randomized traffic; the per-cycle compare against the model does the checking
    tb = m_blocks;
    for (int n = 0; n < 1500; n++) begin
      in_valid = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_key = {$urandom, $urandom, $urandom, $urandom};
      abort = ABORT_EN && $urandom_range(0, 30) == 0;
      rst = $urandom_range(0, 250) == 0;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1; abort = 0; rst = 0;
    repeat (15) @(posedge clk);
    #1;
    check("random_progress", 128'(m_blocks - tb > 20), 128'(1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
